// File: rtl/uart_rx_packet_ctrl.sv
// UART byte-stream packet framer: SYNC, LEN, payload, XOR checksum.
// Holds one checked packet in a register buffer until the consumer releases it.
module uart_rx_packet_ctrl #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int          MAX_LEN   = 8,
    parameter int          TIMEOUT   = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_byte,
    input  logic       rx_ready,
    output logic       pkt_valid,
    input  logic       pkt_ready,
    output logic [3:0] pkt_len,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       err_csum,
    output logic       err_len,
    output logic       err_timeout,
    output logic       overrun
);

    localparam int             AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int             CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 2);
    localparam logic [7:0]     MAX_B   = 8'(MAX_LEN);
    localparam logic [4:0]     MAX_A   = 5'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_HOLD
    } state_t;

    state_t          r_state;
    logic            r_rdy_d;
    logic            r_armed;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_csum;
    logic [3:0]      r_len;
    logic [3:0]      r_idx;
    logic            r_valid;
    logic            r_err_csum;
    logic            r_err_len;
    logic            r_err_to;
    logic            r_ovr;
    logic [7:0]      r_buf [MAX_LEN];

    logic            w_evt;
    logic            w_tmo;
    logic            w_len_bad;
    logic            w_wr;
    logic            w_rd_ok;

    // r_armed blocks a level that was already high when reset released
    assign w_evt     = rx_ready & ~r_rdy_d & r_armed;
    assign w_tmo     = ~w_evt & (r_cnt == TO_LAST);
    assign w_len_bad = (rx_byte == 8'd0) || (rx_byte > MAX_B);
    assign w_wr      = w_evt & (r_state == S_PAYLOAD);
    assign w_rd_ok   = {1'b0, rd_addr} < MAX_A;

    assign pkt_valid   = r_valid;
    assign pkt_len     = r_len;
    assign err_csum    = r_err_csum;
    assign err_len     = r_err_len;
    assign err_timeout = r_err_to;
    assign overrun     = r_ovr;
    assign rd_data     = w_rd_ok ? r_buf[rd_addr[AW-1:0]] : 8'h00;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_buf[r_idx[AW-1:0]] <= rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_rdy_d    <= 1'b0;
            r_armed    <= 1'b0;
            r_cnt      <= '0;
            r_csum     <= 8'h00;
            r_len      <= 4'd0;
            r_idx      <= 4'd0;
            r_valid    <= 1'b0;
            r_err_csum <= 1'b0;
            r_err_len  <= 1'b0;
            r_err_to   <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_rdy_d    <= rx_ready;
            r_armed    <= r_armed | ~rx_ready;
            r_err_csum <= 1'b0;
            r_err_len  <= 1'b0;
            r_err_to   <= 1'b0;
            r_ovr      <= 1'b0;

            // inter-byte watchdog, shared by the three in-packet states
            if (r_state == S_LEN || r_state == S_PAYLOAD || r_state == S_CSUM) begin
                if (w_evt) begin
                    r_cnt <= '0;
                end else if (w_tmo) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_evt && rx_byte == SYNC_BYTE) begin
                        r_state <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (w_evt) begin
                        r_len  <= rx_byte[3:0];
                        r_csum <= rx_byte;
                        r_idx  <= 4'd0;
                        if (w_len_bad) begin
                            r_err_len <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_state <= S_PAYLOAD;
                        end
                    end else if (w_tmo) begin
                        r_err_to <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                S_PAYLOAD: begin
                    if (w_evt) begin
                        r_csum <= r_csum ^ rx_byte;
                        r_idx  <= r_idx + 4'd1;
                        if (r_idx == r_len - 4'd1) begin
                            r_state <= S_CSUM;
                        end
                    end else if (w_tmo) begin
                        r_err_to <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                S_CSUM: begin
                    if (w_evt) begin
                        if (rx_byte == r_csum) begin
                            r_valid <= 1'b1;
                            r_state <= S_HOLD;
                        end else begin
                            r_err_csum <= 1'b1;
                            r_state    <= S_IDLE;
                        end
                    end else if (w_tmo) begin
                        r_err_to <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (w_evt) begin
                        r_ovr <= 1'b1;
                    end
                    if (pkt_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Directed and randomized frames against a frame-level reference model.
// Pulses are counted by a monitor and compared to the model's running totals.
module tb_uart_rx_packet_ctrl;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         MAXL = 8;
    localparam int         TMO  = 1000;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_byte;
    logic       rx_ready;
    logic       pkt_valid;
    logic       pkt_ready;
    logic [3:0] pkt_len;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       err_csum;
    logic       err_len;
    logic       err_timeout;
    logic       overrun;

    uart_rx_packet_ctrl #(
        .SYNC_BYTE(SYNC),
        .MAX_LEN  (MAXL),
        .TIMEOUT  (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_byte    (rx_byte),
        .rx_ready   (rx_ready),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_len    (pkt_len),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .err_csum   (err_csum),
        .err_len    (err_len),
        .err_timeout(err_timeout),
        .overrun    (overrun)
    );

    always #10 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    int cyc    = 0;
    int n_csum = 0;
    int n_len  = 0;
    int n_to   = 0;
    int n_ovr  = 0;
    int n_multi = 0;
    int t_to   = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        n_csum <= n_csum + int'(err_csum);
        n_len  <= n_len + int'(err_len);
        n_to   <= n_to + int'(err_timeout);
        n_ovr  <= n_ovr + int'(overrun);
        if ($countones({err_csum, err_len, err_timeout, overrun}) > 1)
            n_multi <= n_multi + 1;
        if (err_timeout)
            t_to <= cyc;
    end

    // reference model: bytes since SYNC, held packet, expected totals
    logic [7:0] q [$];
    logic [7:0] mpay [$];
    logic [7:0] fr [$];
    logic       held = 1'b0;
    int         mlen = 0;
    int         e_csum = 0;
    int         e_len  = 0;
    int         e_to   = 0;
    int         e_ovr  = 0;
    int         last_ev = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] x;
        if (held) begin
            e_ovr++;
        end else if (q.size() == 0) begin
            if (b == SYNC) q.push_back(b);
        end else begin
            q.push_back(b);
            if (q.size() == 2 && (b == 8'd0 || int'(b) > MAXL)) begin
                e_len++;
                q.delete();
            end else if (q.size() >= 3 && q.size() == int'(q[1]) + 3) begin
                x = 8'h00;
                for (int i = 1; i < q.size() - 1; i++) x ^= q[i];
                if (x == b) begin
                    held = 1'b1;
                    mlen = int'(q[1]);
                    mpay = q[2:q.size()-2];
                end else begin
                    e_csum++;
                end
                q.delete();
            end
        end
    endtask

    task automatic model_reset();
        q.delete();
        held = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int h, input int l);
        rx_byte  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        last_ev = cyc;
        repeat (h - 1) @(negedge clk);
        rx_ready = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic check_all();
        chk("err_csum_count", n_csum, e_csum);
        chk("err_len_count", n_len, e_len);
        chk("err_timeout_count", n_to, e_to);
        chk("overrun_count", n_ovr, e_ovr);
        chk("pkt_valid", pkt_valid, held);
    endtask

    task automatic send_chk(input logic [7:0] b, input int h, input int l);
        send_byte(b, h, l);
        model_byte(b);
        check_all();
    endtask

    task automatic check_pkt();
        chk("pkt_len", pkt_len, mlen);
        for (int i = 0; i < mlen; i++) begin
            rd_addr = 4'(i);
            @(negedge clk);
            chk("rd_data", rd_data, mpay[i]);
        end
    endtask

    task automatic release_pkt();
        pkt_ready = 1'b1;
        @(negedge clk);
        pkt_ready = 1'b0;
        held = 1'b0;
        chk("pkt_valid_release", pkt_valid, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] len, input logic [7:0] flip,
                              input int h, input int l);
        logic [7:0] x;
        logic [7:0] b;
        send_chk(SYNC, h, l);
        send_chk(len, h, l);
        x = len;
        for (int i = 0; i < int'(len); i++) begin
            b = 8'($urandom);
            x ^= b;
            send_chk(b, h, l);
        end
        send_chk(x ^ flip, h, l);
    endtask

    initial begin
        int kind;
        int len;
        logic [7:0] x;
        logic [7:0] b;

        reset     = 1'b1;
        rx_byte   = 8'h00;
        rx_ready  = 1'b0;
        pkt_ready = 1'b0;
        rd_addr   = 4'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_pkt_valid", pkt_valid, 1'b0);
        chk("reset_pkt_len", pkt_len, 4'd0);
        chk("reset_pulses",
            {28'd0, err_csum, err_len, err_timeout, overrun}, 32'd0);

        // basic good frame
        fr = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        foreach (fr[i]) send_chk(fr[i], 1, 2);
        chk("basic_held", pkt_valid, 1'b1);
        check_pkt();
        release_pkt();

        // bad checksum, then a good one-byte frame
        fr = {8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
        foreach (fr[i]) send_chk(fr[i], 2, 1);
        fr = {8'hA5, 8'h01, 8'h7E, 8'h7F};
        foreach (fr[i]) send_chk(fr[i], 1, 1);
        check_pkt();
        release_pkt();

        // illegal lengths
        fr = {8'hA5, 8'h00, 8'hA5, 8'h09, 8'hA5, 8'hF3};
        foreach (fr[i]) send_chk(fr[i], 1, 2);

        // silent line inside a packet
        fr = {8'hA5, 8'h04, 8'h01};
        foreach (fr[i]) send_chk(fr[i], 1, 1);
        repeat (TMO + 5) @(negedge clk);
        e_to++;
        q.delete();
        check_all();
        chk("timeout_latency", t_to - last_ev, TMO - 1);

        // byte landing on the last allowed cycle keeps the packet alive
        fr = {8'hA5, 8'h04, 8'h01};
        foreach (fr[i]) send_chk(fr[i], 1, 1);
        for (int k = 0; k < 2 * TMO && cyc < last_ev + TMO - 2; k++)
            @(negedge clk);
        fr = {8'h02, 8'h03, 8'h04, 8'h00};
        foreach (fr[i]) send_chk(fr[i], 1, 1);
        chk("edge_event_held", pkt_valid, 1'b1);
        check_pkt();

        // bytes while held
        send_chk(8'h5A, 1, 1);
        check_pkt();
        send_chk(SYNC, 3, 2);
        check_pkt();
        release_pkt();
        send_chk(8'h01, 1, 1);

        // long rx_ready level per byte
        send_frame(8'd3, 8'h00, 50, 3);
        check_pkt();
        release_pkt();

        // reset in the middle of the payload
        fr = {8'hA5, 8'h05, 8'h11, 8'h22};
        foreach (fr[i]) send_chk(fr[i], 1, 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        send_frame(8'd2, 8'h00, 1, 1);
        check_pkt();
        release_pkt();

        // rx_ready already high across reset release
        rx_byte  = SYNC;
        rx_ready = 1'b1;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
        fr = {8'h01, 8'h22, 8'h23};
        foreach (fr[i]) send_chk(fr[i], 1, 1);

        // randomized frames
        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 3);
            fr = {};
            if (kind <= 1) begin
                len = $urandom_range(1, MAXL);
                fr.push_back(SYNC);
                fr.push_back(8'(len));
                x = 8'(len);
                for (int i = 0; i < len; i++) begin
                    b = 8'($urandom);
                    x ^= b;
                    fr.push_back(b);
                end
                if (kind == 1) x ^= 8'($urandom_range(1, 255));
                fr.push_back(x);
            end else if (kind == 2) begin
                fr.push_back(SYNC);
                if ($urandom_range(0, 1) == 0) fr.push_back(8'h00);
                else fr.push_back(8'($urandom_range(MAXL + 1, 255)));
            end else begin
                for (int i = 0; i < 3; i++) begin
                    b = 8'($urandom);
                    if (b == SYNC) b = 8'h00;
                    fr.push_back(b);
                end
            end
            foreach (fr[i])
                send_chk(fr[i], $urandom_range(1, 4), $urandom_range(1, 3));
            if (held) begin
                check_pkt();
                if ($urandom_range(0, 1) == 1) begin
                    send_chk(8'($urandom), 1, 1);
                    check_pkt();
                end
                release_pkt();
            end
        end

        chk("pulse_exclusive", n_multi, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_packet_ctrl.md
UART_RX_PACKET_CTRL -- requirements
Module: uart_rx_packet_ctrl

Interface
REQ-001 Parameter SYNC_BYTE, 8'hA5, header byte that opens a packet.
REQ-002 Parameter MAX_LEN, 8, largest legal payload length in bytes (1..15).
REQ-003 Parameter TIMEOUT, 1000, idle clk cycles allowed between bytes inside a packet.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 rx_byte  in  8  byte from the UART receiver; sampled only on an accept event.
REQ-007 rx_ready  in  1  receiver level flag; a 0->1 transition is one accept event.
REQ-008 pkt_valid  out  1  a complete, checked packet is held for the consumer.
REQ-009 pkt_ready  in  1  consumer releases the held packet.
REQ-010 pkt_len  out  4  payload length of the held packet.
REQ-011 rd_addr  in  4  payload read index.
REQ-012 rd_data  out  8  payload byte at rd_addr; combinational from buffer.
REQ-013 err_csum  out  1  one-cycle pulse: checksum mismatch.
REQ-014 err_len  out  1  one-cycle pulse: length 0 or > MAX_LEN.
REQ-015 err_timeout  out  1  one-cycle pulse: inter-byte timeout.
REQ-016 overrun  out  1  one-cycle pulse: byte dropped while a packet is held.

Function
REQ-017 Accept event: registered rx_ready_d; event = rx_ready & ~rx_ready_d; one event per byte regardless of how long rx_ready stays high.
REQ-018 Frame: SYNC_BYTE, LEN, LEN payload bytes, CSUM; CSUM = 8-bit XOR of LEN and all payload bytes.
REQ-019 States IDLE, LEN, PAYLOAD, CSUM, HOLD.
REQ-020 IDLE: event with SYNC_BYTE -> LEN; any other byte is discarded, state unchanged.
REQ-021 LEN: event stores LEN[3:0], seeds checksum with LEN, clears payload index; 1..MAX_LEN -> PAYLOAD; 0 or >MAX_LEN (upper nibble nonzero included) -> err_len pulse, IDLE.
REQ-022 PAYLOAD: event writes byte to buffer[index], XORs into checksum, index+1; after byte LEN -> CSUM.
REQ-023 CSUM: event compares byte to checksum; match -> HOLD with pkt_valid=1 the next cycle; mismatch -> err_csum pulse, IDLE.
REQ-024 HOLD: pkt_valid, pkt_len, buffer stable; pkt_valid & pkt_ready -> IDLE next cycle, pkt_valid=0.
REQ-025 HOLD: any event produces overrun pulse; byte not stored; SYNC_BYTE in HOLD is not remembered.
REQ-026 Timeout counter: cleared on every event and on entering LEN; counts in LEN, PAYLOAD, CSUM; on reaching TIMEOUT-1 without event -> err_timeout pulse, IDLE, partial packet discarded.
REQ-027 Event and timeout in the same cycle: event wins, no error.
REQ-028 Error pulses mutually exclusive, exactly one cycle, registered.
REQ-029 rd_data for rd_addr >= pkt_len is don't-care; valid only while pkt_valid=1.
REQ-030 Buffer is MAX_LEN x 8 registers; not cleared on error, overwritten by next packet.

Reset
REQ-031 Reset: state IDLE, pkt_valid 0, pkt_len 0, all error pulses and overrun 0, timeout counter 0, checksum 0, rx_ready_d 0.
REQ-032 Reset mid-packet or in HOLD discards all progress; no error pulse asserted for it.
REQ-033 rx_ready held high through reset release produces no event until it falls and rises again.

Verification
REQ-034 Bytes A5,03,11,22,33,03 -> pkt_valid=1, pkt_len=3, rd_data[0..2]=11,22,33; pkt_ready=1 -> pkt_valid=0 next cycle.
REQ-035 Bytes A5,02,10,20,31 -> err_csum single pulse, pkt_valid stays 0, state IDLE; next valid frame accepted.
REQ-036 Bytes A5,00 and A5,09 (MAX_LEN=8) -> err_len pulse each, no pkt_valid.
REQ-037 A5,04,01 then TIMEOUT cycles silent -> err_timeout at cycle TIMEOUT-1 after last event; event at that exact cycle -> no error.
REQ-038 Packet held, pkt_ready=0, two further bytes -> two overrun pulses, rd_data unchanged.
REQ-039 rx_ready held high 50 cycles per byte -> each byte counted once; reset asserted during PAYLOAD -> IDLE, no error pulse.
